// File: rtl/mc_ctrl_unit.sv
// Multi-cycle sequencer for the RV32I-subset datapath: one FSM state per clk edge.
// Build option MC_CTRL_ILLEGAL_TRAP_EN: illegal instructions halt the FSM instead of acting as NOPs.
// state | meaning: FETCH/DECODE | IR load, dispatch; EX_*/MEM_*/WB_ALU | execute phases;
// BRANCH/JAL/LUI | single-cycle tails; HALT | parked after an illegal instruction (trap build only)
module mc_ctrl_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wdata_sel,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [3:0]  alu_op,
    output logic        mem_write,
    output logic        mdr_write,
    output logic [3:0]  state,
    output logic [31:0] instr_cnt,
    output logic        illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EX_R     = 4'd2,
        EX_I     = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        HALT     = 4'd15
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam state_e ILL_NEXT = HALT;
`else
    localparam state_e ILL_NEXT = FETCH;
`endif

    state_e      state_q, state_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    // allow_sub is low for immediate ops so ADDI never becomes SUB
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7,
                                           input logic allow_sub);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (f7 && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = 4'd2;
            3'b010:  op = 4'd3;
            3'b011:  op = 4'd4;
            3'b100:  op = 4'd5;
            3'b101:  op = f7 ? 4'd7 : 4'd6;
            3'b110:  op = 4'd8;
            default: op = 4'd9;
        endcase
        return op;
    endfunction

    logic       br_legal;
    logic       br_taken;
    logic       is_imm_op;

    assign br_legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign br_taken  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
    assign is_imm_op = (opcode == OP_I);

    always_comb begin
        state_d   = state_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        reg_write = 1'b0;
        wdata_sel = 2'b00;
        alu_a_sel = 1'b0;
        alu_b_sel = 2'b00;
        alu_op    = ALU_ADD;
        mem_write = 1'b0;
        mdr_write = 1'b0;

        case (state_q)
            FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_R:               state_d = EX_R;
                    OP_I:               state_d = EX_I;
                    OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
                    OP_BRANCH:          state_d = BRANCH;
                    OP_JAL:             state_d = JAL;
                    OP_LUI:             state_d = LUI;
                    default:            state_d = ILL_NEXT;
                endcase
            end
            EX_R: begin
                alu_op  = alu_dec(funct3, funct7b5, 1'b1);
                state_d = WB_ALU;
            end
            EX_I: begin
                alu_b_sel = 2'b01;
                alu_op    = alu_dec(funct3, funct7b5, 1'b0);
                state_d   = WB_ALU;
            end
            WB_ALU: begin
                // IR is unchanged, so the execute-phase ALU setup is recomputed from it
                alu_b_sel = is_imm_op ? 2'b01 : 2'b00;
                alu_op    = alu_dec(funct3, funct7b5, !is_imm_op);
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            MEM_ADDR: begin
                alu_b_sel = 2'b01;
                state_d   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mdr_write = 1'b1;
                state_d   = MEM_WB;
            end
            MEM_WB: begin
                reg_write = 1'b1;
                wdata_sel = 2'b01;
                state_d   = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_op   = ALU_SUB;
                pc_src   = 2'b01;
                pc_write = br_taken;
                state_d  = br_legal ? FETCH : ILL_NEXT;
            end
            JAL: begin
                reg_write = 1'b1;
                wdata_sel = 2'b10;
                pc_write  = 1'b1;
                pc_src    = 2'b01;
                state_d   = FETCH;
            end
            LUI: begin
                reg_write = 1'b1;
                wdata_sel = 2'b11;
                state_d   = FETCH;
            end
            HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                state_d = HALT;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase

        if (!rst_n) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'b00;
            reg_write = 1'b0;
            wdata_sel = 2'b00;
            alu_a_sel = 1'b0;
            alu_b_sel = 2'b00;
            alu_op    = ALU_ADD;
            mem_write = 1'b0;
            mdr_write = 1'b0;
        end
    end

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        if ((state_q != FETCH) && (state_d == FETCH))
            instr_cnt_d = instr_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            instr_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q | (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: walks each instruction class through its states
// and compares strobes, selects and the retire count against hand-derived values.
module tb_mc_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        ir_write, pc_write, reg_write, alu_a_sel, mem_write, mdr_write, illegal;
    logic [1:0]  pc_src, wdata_sel, alu_b_sel;
    logic [3:0]  alu_op, state;
    logic [31:0] instr_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .zero      (zero),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .wdata_sel (wdata_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .mem_write (mem_write),
        .mdr_write (mdr_write),
        .state     (state),
        .instr_cnt (instr_cnt),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] instr);
        opcode   = instr[6:0];
        funct3   = instr[14:12];
        funct7b5 = instr[30];
    endtask

    // active edge is posedge; everything is driven and sampled on negedge
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        zero  = 1'b0;
        load(32'h002081B3);
        step(); step();
        chk("rst_state",    {28'd0, state}, 32'd0);
        chk("rst_ir_write", {31'd0, ir_write}, 32'd0);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
        chk("rst_cnt",      instr_cnt, 32'd0);
        chk("rst_illegal",  {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("fetch_ir_write", {31'd0, ir_write}, 32'd1);
        chk("fetch_pc_write", {31'd0, pc_write}, 32'd1);

        // ADD x3,x1,x2
        step(); chk("add_s1", {28'd0, state}, 32'd1);
        step(); chk("add_s2", {28'd0, state}, 32'd2);
        chk("add_aluop", {28'd0, alu_op}, 32'd0);
        chk("add_bsel",  {30'd0, alu_b_sel}, 32'd0);
        step(); chk("add_s8", {28'd0, state}, 32'd8);
        chk("add_regw",  {31'd0, reg_write}, 32'd1);
        chk("add_wsel",  {30'd0, wdata_sel}, 32'd0);
        chk("add_cnt_before", instr_cnt, 32'd0);
        step(); chk("add_s0", {28'd0, state}, 32'd0);
        chk("add_cnt_after", instr_cnt, 32'd1);

        // SUB
        load(32'h402081B3);
        step(); step(); chk("sub_s2", {28'd0, state}, 32'd2);
        chk("sub_aluop", {28'd0, alu_op}, 32'd1);
        step(); chk("sub_wb_aluop", {28'd0, alu_op}, 32'd1);
        step(); chk("sub_cnt", instr_cnt, 32'd2);

        // ADDI with bit30 set stays ADD
        load(32'h40008093);
        step(); step(); chk("addi_s3", {28'd0, state}, 32'd3);
        chk("addi_aluop", {28'd0, alu_op}, 32'd0);
        chk("addi_bsel",  {30'd0, alu_b_sel}, 32'd1);
        step(); chk("addi_wb_bsel", {30'd0, alu_b_sel}, 32'd1);
        step(); chk("addi_cnt", instr_cnt, 32'd3);

        // SRAI
        load(32'h4010D093);
        step(); step(); chk("srai_aluop", {28'd0, alu_op}, 32'd7);
        step(); step(); chk("srai_cnt", instr_cnt, 32'd4);

        // LW
        load(32'h0000A183);
        step(); step(); chk("lw_s4", {28'd0, state}, 32'd4);
        chk("lw_addr_bsel", {30'd0, alu_b_sel}, 32'd1);
        step(); chk("lw_s5", {28'd0, state}, 32'd5);
        chk("lw_mdrw", {31'd0, mdr_write}, 32'd1);
        chk("lw_memw", {31'd0, mem_write}, 32'd0);
        step(); chk("lw_s6", {28'd0, state}, 32'd6);
        chk("lw_wsel", {30'd0, wdata_sel}, 32'd1);
        chk("lw_regw", {31'd0, reg_write}, 32'd1);
        step(); chk("lw_s0", {28'd0, state}, 32'd0);
        chk("lw_cnt", instr_cnt, 32'd5);

        // SW
        load(32'h0020A023);
        step(); step(); chk("sw_s4", {28'd0, state}, 32'd4);
        chk("sw_addr_memw", {31'd0, mem_write}, 32'd0);
        step(); chk("sw_s7", {28'd0, state}, 32'd7);
        chk("sw_memw", {31'd0, mem_write}, 32'd1);
        chk("sw_regw", {31'd0, reg_write}, 32'd0);
        step(); chk("sw_s0", {28'd0, state}, 32'd0);
        chk("sw_cnt", instr_cnt, 32'd6);

        // BEQ: taken on zero, not taken otherwise
        load(32'h00208463);
        zero = 1'b1;
        step(); step(); chk("beq_s9", {28'd0, state}, 32'd9);
        chk("beq_z1_pcw",  {31'd0, pc_write}, 32'd1);
        chk("beq_pcsrc",   {30'd0, pc_src}, 32'd1);
        chk("beq_aluop",   {28'd0, alu_op}, 32'd1);
        zero = 1'b0; #1;
        chk("beq_z0_pcw",  {31'd0, pc_write}, 32'd0);
        step(); chk("beq_s0", {28'd0, state}, 32'd0);
        chk("beq_cnt", instr_cnt, 32'd7);

        // BNE: inverse sense
        load(32'h00209463);
        zero = 1'b1;
        step(); step(); chk("bne_z1_pcw", {31'd0, pc_write}, 32'd0);
        zero = 1'b0; #1;
        chk("bne_z0_pcw", {31'd0, pc_write}, 32'd1);
        step(); chk("bne_cnt", instr_cnt, 32'd8);

        // JAL
        load(32'h0000006F);
        step(); step(); chk("jal_s10", {28'd0, state}, 32'd10);
        chk("jal_regw",  {31'd0, reg_write}, 32'd1);
        chk("jal_wsel",  {30'd0, wdata_sel}, 32'd2);
        chk("jal_pcw",   {31'd0, pc_write}, 32'd1);
        chk("jal_pcsrc", {30'd0, pc_src}, 32'd1);
        step(); chk("jal_cnt", instr_cnt, 32'd9);

        // LUI
        load(32'h000000B7);
        step(); step(); chk("lui_s11", {28'd0, state}, 32'd11);
        chk("lui_wsel", {30'd0, wdata_sel}, 32'd3);
        chk("lui_regw", {31'd0, reg_write}, 32'd1);
        step(); chk("lui_s0", {28'd0, state}, 32'd0);
        chk("lui_cnt", instr_cnt, 32'd10);

        // Reset pulse in the middle of MEM_RD
        load(32'h0000A183);
        step(); step(); step(); chk("rmid_s5", {28'd0, state}, 32'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid_state", {28'd0, state}, 32'd0);
        chk("rmid_mdrw",  {31'd0, mdr_write}, 32'd0);
        chk("rmid_irw",   {31'd0, ir_write}, 32'd0);
        chk("rmid_pcw",   {31'd0, pc_write}, 32'd0);
        chk("rmid_regw",  {31'd0, reg_write}, 32'd0);
        chk("rmid_cnt",   instr_cnt, 32'd0);
        #4 rst_n = 1'b1;
        step();
        chk("rmid_after_state", {28'd0, state}, 32'd0);
        chk("rmid_after_irw",   {31'd0, ir_write}, 32'd1);

        // Illegal opcode 0x7F
        load(32'h0000007F);
        step(); chk("ill_s1", {28'd0, state}, 32'd1);
        step();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        chk("ill_halt",    {28'd0, state}, 32'd15);
        chk("ill_flag",    {31'd0, illegal}, 32'd1);
        chk("ill_cnt",     instr_cnt, 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("ill_hold_state", {28'd0, state}, 32'd15);
        chk("ill_hold_cnt",   instr_cnt, 32'd0);
        chk("ill_hold_irw",   {31'd0, ir_write}, 32'd0);
`else
        chk("ill_fetch", {28'd0, state}, 32'd0);
        chk("ill_cnt",   instr_cnt, 32'd1);
        chk("ill_flag",  {31'd0, illegal}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_unit.md
# mc_ctrl_unit

Multi-cycle control unit for the RV32I-subset CPU datapath. A state machine sequences fetch, decode, execute, memory and write-back phases. It drives every register-enable and mux-select of the datapath, which exposes PC, IR, MDR and the register-file write data. It sits beside the datapath inside `cpu` and advances one state per `clk` rising edge, including single-stepped board clocks.

## Interface
- No parameters.
- `clk` in 1: datapath clock; board button or free-running.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7b5` in 1: IR[30].
- `zero` in 1: ALU zero flag (combinational).
- `ir_write` out 1: load IR from instruction memory; datapath also latches PC0 <= PC.
- `pc_write` out 1: load PC.
- `pc_src` out 2: 00 = PC+4; 01 = PC0+imm.
- `reg_write` out 1: register-file write enable.
- `wdata_sel` out 2: 00 = ALU F; 01 = MDR; 10 = PC (link); 11 = imm.
- `alu_a_sel` out 1: 0 = reg A.
- `alu_b_sel` out 2: 00 = reg B; 01 = imm.
- `alu_op` out 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- `mem_write` out 1: data-memory write.
- `mdr_write` out 1: load MDR from data memory.
- `state` out 4: current state, for debug and LEDs.
- `instr_cnt` out 32: retired-instruction count.
- `illegal` out 1: sticky illegal-instruction flag.

## Operation
- States: FETCH=0, DECODE=1, EX_R=2, EX_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, WB_ALU=8, BRANCH=9, JAL=10, LUI=11, HALT=15.
- FETCH: `ir_write`=1, `pc_write`=1, `pc_src`=00. Next state is DECODE.
- DECODE dispatches on `opcode`:
  - 0110011 -> EX_R
  - 0010011 -> EX_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else -> illegal handling (see Configuration).
- EX_R: `alu_b_sel`=00. `alu_op` comes from funct3, with funct3 000 + `funct7b5`=1 giving SUB and funct3 101 + `funct7b5`=1 giving SRA. Next state is WB_ALU.
- EX_I: `alu_b_sel`=01. Same mapping as EX_R, except `funct7b5` is ignored for funct3 000, so ADDI never becomes SUB. Next state is WB_ALU.
- WB_ALU: `reg_write`=1, `wdata_sel`=00. The ALU inputs of the previous state are held. Next state is FETCH.
- MEM_ADDR: ADD with A + imm. Next state is MEM_RD for load, MEM_WR for store.
- MEM_RD: `mdr_write`=1. Next state is MEM_WB.
- MEM_WB: `reg_write`=1, `wdata_sel`=01. Next state is FETCH.
- MEM_WR: `mem_write`=1. Next state is FETCH.
- BRANCH: SUB with A − B, `pc_src`=01.
  - `pc_write` = (funct3==000 & `zero`) | (funct3==001 & ~`zero`). This is the only Mealy output.
  - Any other funct3 is illegal.
  - Next state is FETCH.
- JAL: `reg_write`=1, `wdata_sel`=10 (PC already equals PC0+4), `pc_write`=1, `pc_src`=01. Next state is FETCH.
- LUI: `reg_write`=1, `wdata_sel`=11. Next state is FETCH.
- Outputs not listed for a state are 0; `alu_op` defaults to ADD.
- `instr_cnt` increments on each edge that moves the FSM from a non-FETCH state into FETCH. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - `rst_n`=0 immediately forces state=FETCH, `instr_cnt`=0 and `illegal`=0.
  - All write enables (`ir_write`, `pc_write`, `reg_write`, `mem_write`, `mdr_write`) are forced to 0 while `rst_n` is low.
  - All select outputs read 0 during reset.
- The first rising edge after release executes FETCH.
- Reset asserted in any state, mid-instruction included, aborts that instruction with no further writes and no count increment.
- Outputs decode combinationally from the registered state, except the BRANCH `pc_write`. Datapath registers sample on the same edge that advances the FSM.
- Cycles per instruction: R/I ALU 4, load 5, store 4, branch 3, JAL 3, LUI 3.
- No stalls or handshakes; memories are single-cycle.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode, or branch funct3 other than 000/001, moves DECODE or BRANCH to HALT and sets `illegal`=1.
  - In HALT all enables are 0 and the FSM stays in HALT until `rst_n`.
  - HALT entry does not increment `instr_cnt`.
- Undefined:
  - The illegal instruction is a NOP: DECODE goes to FETCH, or BRANCH goes to FETCH with `pc_write`=0.
  - `instr_cnt` increments.
  - `illegal` is tied 0 and HALT is unreachable.

## Test plan
- Reset mid-MEM_RD (`rst_n` pulsed low 5 ns) -> state=0, all enables 0 during low, `instr_cnt`=0, next edge asserts `ir_write`.
- ADD x3,x1,x2 (0x002081B3) -> states 0,1,2,8. `alu_op`=0 in EX_R; `reg_write`=1 `wdata_sel`=00 in WB_ALU. `instr_cnt` 0→1 on the 4th edge.
- SUB 0x402081B3 -> `alu_op`=1. ADDI 0x40008093 (bit30=1) -> `alu_op`=0. SRAI 0x4010D093 -> `alu_op`=7.
- LW 0x0000A183 -> states 0,1,4,5,6 with `mdr_write` in 5 and `wdata_sel`=01 in 6. SW 0x0020A023 -> states 0,1,4,7 with `mem_write`=1 only in 7.
- BEQ 0x00208463:
  - `zero`=1 -> `pc_write`=1 `pc_src`=01 in BRANCH.
  - `zero`=0 -> `pc_write`=0.
  - BNE (funct3 001) gives the inverse.
- Opcode 0x7F:
  - With `MC_CTRL_ILLEGAL_TRAP_EN` -> state=15, `illegal`=1, count held across 10 further clocks.
  - Without -> back to FETCH after DECODE, count +1.
